div_arbiter: RTL and testbench
==============================

# div_arbiter

Two-port arbiter and sequencer for the shared 4-bit non-restoring `divider`. It accepts division requests from two requesters over valid/ready handshakes and grants them round-robin. It issues one `start` pulse per accepted request, waits a fixed divider latency, and returns quotient/remainder to the originating port over a held valid/ready response. Divide-by-zero is detected locally and never reaches the divider.

## Interface
Parameters:
- `WIDTH`, 4: operand/result width; must match the `divider` instance.
- `DIV_LAT`, 6: cycles from the cycle `div_start` is high to the cycle `div_quotient`/`div_remain` are valid; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `n_rst`  in  1  reset, synchronous, active-low.
- `req0_valid`  in  1  requester 0 has a request.
- `req0_m`  in  WIDTH  requester 0 divisor.
- `req0_q`  in  WIDTH  requester 0 dividend.
- `req0_ready`  out  1  request 0 accepted this cycle when valid&ready.
- `req1_valid`, `req1_m`, `req1_q`, `req1_ready`: same as port 0, for requester 1.
- `rsp0_valid`  out  1  response 0 available; held until taken.
- `rsp0_ready`  in  1  requester 0 takes response.
- `rsp0_quotient`  out  WIDTH  quotient.
- `rsp0_remain`  out  WIDTH  remainder.
- `rsp0_dz`  out  1  divide-by-zero flag.
- `rsp1_*`: same as port 0, for requester 1.
- `div_start`  out  1  one-cycle start pulse to `divider.start`.
- `div_m`  out  WIDTH  to `divider.M`; stable from ISSUE through WAIT.
- `div_q`  out  WIDTH  to `divider.Q`; stable from ISSUE through WAIT.
- `div_quotient`  in  WIDTH  from `divider.quotient`.
- `div_remain`  in  WIDTH  from `divider.remain`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. One request is in flight at a time.
- Arbitration in IDLE:
  - Single valid requester: that requester is granted.
  - Both valid: the port not served last is granted.
  - `last_grant` resets to 1, so port 0 wins the first tie.
- `reqN_ready` is combinational: it is 1 only in IDLE, and only for the granted port. The other port's ready is 0.
- On handshake: latch M, Q and the grant index, then branch on the divisor:
  - M==0: go to RESP with quotient={WIDTH{1}}, remain=Q, dz=1. The divider is not started.
  - M!=0: go to ISSUE.
- ISSUE: `div_start`=1 for exactly one cycle, load the wait counter with DIV_LAT-1, go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle the counter reaches 0, latch `div_quotient`/`div_remain` with dz=0, then go to RESP.
- RESP: `rspN_valid`=1 on the granted port only. Data and dz are held stable until `rspN_ready`.
  - On `rspN_valid`&`rspN_ready`: update `last_grant` to the served port and return to IDLE.
- Requests arriving while busy wait with ready=0. Requesters must hold valid and operands until accepted.
- `div_m`/`div_q` drive the latched operands in all states. They are 0 after reset.
- Reset (n_rst=0 at a clock edge):
  - State goes to IDLE; all outputs and latched registers go to 0; `last_grant` goes to 1.
  - Reset is honored in any state, including mid-WAIT. An in-flight result is discarded; the divider shares `n_rst`.

## Timing
- Handshake in IDLE at cycle T, nonzero divisor:
  - `div_start`=1 in T+1.
  - WAIT covers T+2..T+DIV_LAT+1.
  - `rspN_valid` rises in T+DIV_LAT+2 (T+8 at default).
- Zero divisor: `rspN_valid` rises in T+1.
- Response taken in cycle R: the next request can be accepted in R+1 at the earliest, so there is one idle bubble.
- Throughput with ready held high: one division per DIV_LAT+3 cycles.
- `rspN_valid` never rises on both ports at once. It never drops without the matching ready.
- Reset values: all `req*_ready`, `rsp*_valid`, `div_start`, and all data outputs are 0.

## Test plan
- Port 0 only, M=11, Q=15, rsp0_ready=1 → one `div_start` pulse; rsp0_valid 8 cycles after accept; quotient=1, remain=4, dz=0.
- Both ports valid in the same cycle after reset: port0 (M=3, Q=15) and port1 (M=3, Q=11) → port 0 granted first (q=5, r=0); port 1 granted next (q=3, r=2); exactly two `div_start` pulses.
- Back-to-back ties: both ports hold requests continuously, with port0 (M=4, Q=12) → grants alternate 0,1,0,1; port0 always returns q=3, r=0.
- Port 1, M=0, Q=9 → no `div_start`; rsp1_valid in the cycle after accept; q=15, r=9, dz=1.
- Backpressure: rsp0_ready held 0 for 5 cycles → rsp0_valid and data stay stable; port 1 stays not ready until the response is taken.
- Pull n_rst low during WAIT → next cycle: IDLE, all outputs 0; no response is delivered; a new port-0 request then completes normally.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: two-port round-robin arbiter and sequencer in front of a shared
// WIDTH-bit divider. One division is in flight at a time. Divide-by-zero is
// answered locally without starting the divider.
//
// Ports:
//   clk, n_rst              clock, synchronous active-low reset
//   reqN_valid/m/q/ready    request handshake (N = 0, 1); m = divisor, q = dividend
//   rspN_valid/ready        response handshake, data held until taken
//   rspN_quotient/remain/dz response payload
//   div_start/m/q           to the divider (start pulse and operands)
//   div_quotient/remain     from the divider, valid DIV_LAT cycles after start
module div_arbiter #(
    parameter int WIDTH   = 4,
    parameter int DIV_LAT = 6
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_m,
    input  logic [WIDTH-1:0] req0_q,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_m,
    input  logic [WIDTH-1:0] req1_q,
    output logic             req1_ready,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_quotient,
    output logic [WIDTH-1:0] rsp0_remain,
    output logic             rsp0_dz,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_quotient,
    output logic [WIDTH-1:0] rsp1_remain,
    output logic             rsp1_dz,
    output logic             div_start,
    output logic [WIDTH-1:0] div_m,
    output logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remain
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_q, grant_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic [3:0]       cnt_q, cnt_d;

    logic             grant_sel;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_m;
    logic [WIDTH-1:0] sel_q;
    logic             rsp_take;

    // Arbitration: a lone requester wins; on a tie the port not served last wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant_q;
        end else begin
            grant_sel = req1_valid;
        end
        sel_valid = grant_sel ? req1_valid : req0_valid;
        sel_m     = grant_sel ? req1_m     : req0_m;
        sel_q     = grant_sel ? req1_q     : req0_q;
        rsp_take  = grant_q   ? rsp1_ready : rsp0_ready;
    end

    assign req0_ready    = (state_q == IDLE) && req0_valid && !grant_sel;
    assign req1_ready    = (state_q == IDLE) && req1_valid &&  grant_sel;
    assign rsp0_valid    = (state_q == RESP) && !grant_q;
    assign rsp1_valid    = (state_q == RESP) &&  grant_q;
    assign rsp0_quotient = quot_q;
    assign rsp0_remain   = rem_q;
    assign rsp0_dz       = dz_q;
    assign rsp1_quotient = quot_q;
    assign rsp1_remain   = rem_q;
    assign rsp1_dz       = dz_q;
    assign div_start     = (state_q == ISSUE);
    assign div_m         = m_q;
    assign div_q         = q_q;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        m_d          = m_q;
        q_d          = q_q;
        quot_d       = quot_q;
        rem_d        = rem_q;
        dz_d         = dz_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    grant_d = grant_sel;
                    m_d     = sel_m;
                    q_d     = sel_q;
                    if (sel_m == '0) begin
                        // Answered locally; the divider never sees a zero divisor.
                        quot_d  = '1;
                        rem_d   = sel_q;
                        dz_d    = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = 4'(DIV_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    quot_d  = div_quotient;
                    rem_d   = div_remain;
                    dz_d    = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_take) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            m_q          <= '0;
            q_q          <= '0;
            quot_q       <= '0;
            rem_q        <= '0;
            dz_q         <= 1'b0;
            cnt_q        <= 4'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            m_q          <= m_d;
            q_q          <= q_d;
            quot_q       <= quot_d;
            rem_q        <= rem_d;
            dz_q         <= dz_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter. A behavioural divider answers exactly
// DIV_LAT cycles after each start pulse (inverted data otherwise). Expected
// responses are pushed to a scoreboard at request handshake and compared when
// the response handshake occurs.
module tb_div_arbiter;

    localparam int WIDTH   = 4;
    localparam int DIV_LAT = 6;

    typedef struct {
        logic             port;
        logic [WIDTH-1:0] quot;
        logic [WIDTH-1:0] rem;
        logic             dz;
    } exp_t;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic [WIDTH-1:0] req0_m = '0, req0_q = '0, req1_m = '0, req1_q = '0;
    logic             req0_ready, req1_ready;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [WIDTH-1:0] rsp0_quotient, rsp0_remain, rsp1_quotient, rsp1_remain;
    logic             rsp0_dz, rsp1_dz;
    logic             div_start;
    logic [WIDTH-1:0] div_m, div_q;
    logic [WIDTH-1:0] div_quotient, div_remain;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   start_cnt = 0;
    int   last_start_cyc = -1;
    int   rsp_rises = 0;
    logic both_seen = 1'b0;
    logic rsp0_prev = 1'b0, rsp1_prev = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    div_arbiter #(.WIDTH(WIDTH), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .n_rst(n_rst),
        .req0_valid(req0_valid), .req0_m(req0_m), .req0_q(req0_q), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_m(req1_m), .req1_q(req1_q), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_quotient(rsp0_quotient),
        .rsp0_remain(rsp0_remain), .rsp0_dz(rsp0_dz),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_quotient(rsp1_quotient),
        .rsp1_remain(rsp1_remain), .rsp1_dz(rsp1_dz),
        .div_start(div_start), .div_m(div_m), .div_q(div_q),
        .div_quotient(div_quotient), .div_remain(div_remain)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // Behavioural divider: result visible only in the cycle DIV_LAT after start.
    logic             dv_busy = 1'b0;
    logic [3:0]       dv_cnt = 4'd0;
    logic [WIDTH-1:0] dv_quot = '0, dv_rem = '0;
    always @(posedge clk) begin
        if (!n_rst) begin
            dv_busy <= 1'b0;
        end else if (div_start) begin
            dv_busy <= 1'b1;
            dv_cnt  <= 4'(DIV_LAT - 1);
            dv_quot <= (div_m == 0) ? '1 : div_q / div_m;
            dv_rem  <= (div_m == 0) ? div_q : div_q % div_m;
        end else if (dv_busy) begin
            if (dv_cnt == 0) dv_busy <= 1'b0;
            else             dv_cnt  <= dv_cnt - 4'd1;
        end
    end
    assign div_quotient = (dv_busy && dv_cnt == 0) ? dv_quot : ~dv_quot;
    assign div_remain   = (dv_busy && dv_cnt == 0) ? dv_rem  : ~dv_rem;

    function automatic exp_t model(input logic port, input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
        exp_t e;
        e.port = port;
        if (m == 0) begin
            e.quot = '1;
            e.rem  = q;
            e.dz   = 1'b1;
        end else begin
            e.quot = q / m;
            e.rem  = q % m;
            e.dz   = 1'b0;
        end
        return e;
    endfunction

    // Monitor: scoreboard push/pop and event bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        if (req0_valid && req0_ready) sb.push_back(model(1'b0, req0_m, req0_q));
        if (req1_valid && req1_ready) sb.push_back(model(1'b1, req1_m, req1_q));
        if (div_start) begin
            start_cnt++;
            last_start_cyc = cyc;
        end
        if (rsp0_valid && rsp1_valid) both_seen = 1'b1;
        if ((rsp0_valid && !rsp0_prev) || (rsp1_valid && !rsp1_prev)) rsp_rises++;
        rsp0_prev = rsp0_valid;
        rsp1_prev = rsp1_valid;
        if (rsp0_valid && rsp0_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_port0: unexpected response q=%0d r=%0d dz=%0b, none expected",
                         rsp0_quotient, rsp0_remain, rsp0_dz);
            end else begin
                mon_e = sb.pop_front();
                if ({1'b0, rsp0_quotient, rsp0_remain, rsp0_dz} !== {mon_e.port, mon_e.quot, mon_e.rem, mon_e.dz}) begin
                    errors++;
                    $display("FAIL sb_port0: got port=0 q=%0d r=%0d dz=%0b, want port=%0d q=%0d r=%0d dz=%0b",
                             rsp0_quotient, rsp0_remain, rsp0_dz, mon_e.port, mon_e.quot, mon_e.rem, mon_e.dz);
                end
            end
        end
        if (rsp1_valid && rsp1_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_port1: unexpected response q=%0d r=%0d dz=%0b, none expected",
                         rsp1_quotient, rsp1_remain, rsp1_dz);
            end else begin
                mon_e = sb.pop_front();
                if ({1'b1, rsp1_quotient, rsp1_remain, rsp1_dz} !== {mon_e.port, mon_e.quot, mon_e.rem, mon_e.dz}) begin
                    errors++;
                    $display("FAIL sb_port1: got port=1 q=%0d r=%0d dz=%0b, want port=%0d q=%0d r=%0d dz=%0b",
                             rsp1_quotient, rsp1_remain, rsp1_dz, mon_e.port, mon_e.quot, mon_e.rem, mon_e.dz);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait for its handshake, then withdraw it. t = accept cycle.
    task automatic send(input logic port, input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q, output int t);
        t = -1;
        if (port) begin req1_m = m; req1_q = q; req1_valid = 1'b1; end
        else      begin req0_m = m; req0_q = q; req0_valid = 1'b1; end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (port ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) begin
                t = cyc;
                break;
            end
        end
        tick();
        if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
        checks++;
        if (t < 0) begin
            errors++;
            $display("FAIL send_port%0d: no handshake within 60 cycles, want accept", port);
        end
    endtask

    // Wait for rspN_valid; returns sitting at the negedge of the cycle it was seen.
    task automatic wait_rsp(input logic port, output int r);
        r = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (port ? rsp1_valid : rsp0_valid) begin
                r = cyc;
                break;
            end
        end
        checks++;
        if (r < 0) begin
            errors++;
            $display("FAIL rsp_port%0d: no response within 60 cycles, want valid", port);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, div_start} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, want 00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, div_start});
        end
        checks++;
        if ({div_m, div_q, rsp0_quotient, rsp0_remain, rsp0_dz, rsp1_quotient, rsp1_remain, rsp1_dz} !== '0) begin
            errors++;
            $display("FAIL reset_data: got m=%0d q=%0d rq0=%0d rr0=%0d dz0=%0b, want all 0",
                     div_m, div_q, rsp0_quotient, rsp0_remain, rsp0_dz);
        end
        tick();
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int t, r, s0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        s0 = start_cnt;
        send(1'b0, 4'd11, 4'd15, t);
        wait_rsp(1'b0, r);
        checks++;
        if (r - t != DIV_LAT + 2) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles, want %0d", r - t, DIV_LAT + 2);
        end
        checks++;
        if ({rsp0_quotient, rsp0_remain, rsp0_dz} !== {4'd1, 4'd4, 1'b0}) begin
            errors++;
            $display("FAIL single_data: got q=%0d r=%0d dz=%0b, want q=1 r=4 dz=0", rsp0_quotient, rsp0_remain, rsp0_dz);
        end
        checks++;
        if (last_start_cyc != t + 1) begin
            errors++;
            $display("FAIL single_start_cycle: got %0d, want %0d", last_start_cyc, t + 1);
        end
        repeat (3) tick();
        checks++;
        if (start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL single_start_count: got %0d, want 1", start_cnt - s0);
        end
    endtask

    // Collect n grants while both ports present requests; valids held unless drop_each.
    task automatic run_tie(input int n, input logic drop_each, output logic order[4], output int gcyc[4]);
        int   got;
        logic g0, g1;
        got = 0;
        for (int c = 0; c < 200 && got < n; c++) begin
            @(negedge clk);
            g0 = req0_valid && req0_ready;
            g1 = req1_valid && req1_ready;
            if (g0 || g1) begin
                order[got] = g1;
                gcyc[got]  = cyc;
                got++;
            end
            tick();
            if (drop_each && g0) req0_valid = 1'b0;
            if (drop_each && g1) req1_valid = 1'b0;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL tie_grants: got %0d grants, want %0d", got, n);
        end
        for (int c = 0; c < 60 && sb.size() != 0; c++) tick();
    endtask

    task automatic test_tie();
        logic order[4];
        int   gcyc[4];
        int   s0;
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        s0 = start_cnt;
        req0_m = 4'd3; req0_q = 4'd15; req0_valid = 1'b1;
        req1_m = 4'd3; req1_q = 4'd11; req1_valid = 1'b1;
        run_tie(2, 1'b1, order, gcyc);
        checks++;
        if ({order[0], order[1]} !== 2'b01) begin
            errors++;
            $display("FAIL tie_order: got %0d,%0d, want 0,1", order[0], order[1]);
        end
        checks++;
        if (start_cnt - s0 != 2) begin
            errors++;
            $display("FAIL tie_start_count: got %0d, want 2", start_cnt - s0);
        end
    endtask

    task automatic test_back_to_back();
        logic order[4];
        int   gcyc[4];
        req0_m = 4'd4; req0_q = 4'd12; req0_valid = 1'b1;
        req1_m = 4'd5; req1_q = 4'd13; req1_valid = 1'b1;
        run_tie(4, 1'b0, order, gcyc);
        checks++;
        if ({order[0], order[1], order[2], order[3]} !== 4'b0101) begin
            errors++;
            $display("FAIL b2b_order: got %b, want 0101", {order[0], order[1], order[2], order[3]});
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (gcyc[i+1] - gcyc[i] != DIV_LAT + 3) begin
                errors++;
                $display("FAIL b2b_spacing%0d: got %0d cycles, want %0d", i, gcyc[i+1] - gcyc[i], DIV_LAT + 3);
            end
        end
    endtask

    task automatic test_div_zero();
        int t, r, s0;
        s0 = start_cnt;
        send(1'b1, 4'd0, 4'd9, t);
        wait_rsp(1'b1, r);
        checks++;
        if (r != t + 1) begin
            errors++;
            $display("FAIL dz_latency: got %0d cycles, want 1", r - t);
        end
        checks++;
        if ({rsp1_quotient, rsp1_remain, rsp1_dz} !== {4'd15, 4'd9, 1'b1}) begin
            errors++;
            $display("FAIL dz_data: got q=%0d r=%0d dz=%0b, want q=15 r=9 dz=1", rsp1_quotient, rsp1_remain, rsp1_dz);
        end
        repeat (3) tick();
        checks++;
        if (start_cnt != s0) begin
            errors++;
            $display("FAIL dz_start: got %0d start pulses, want 0", start_cnt - s0);
        end
    endtask

    task automatic test_backpressure();
        int t, r, r1;
        logic [WIDTH-1:0] cq, cr;
        logic             cdz;
        rsp0_ready = 1'b0;
        send(1'b0, 4'd5, 4'd14, t);
        req1_m = 4'd2; req1_q = 4'd9; req1_valid = 1'b1;
        wait_rsp(1'b0, r);
        cq = rsp0_quotient; cr = rsp0_remain; cdz = rsp0_dz;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if ({rsp0_valid, rsp0_quotient, rsp0_remain, rsp0_dz, req1_ready} !== {1'b1, cq, cr, cdz, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%0b q=%0d r=%0d dz=%0b rdy1=%0b, want v=1 q=%0d r=%0d dz=%0b rdy1=0",
                         i, rsp0_valid, rsp0_quotient, rsp0_remain, rsp0_dz, req1_ready, cq, cr, cdz);
            end
        end
        tick();
        rsp0_ready = 1'b1;
        @(negedge clk);
        r = cyc;
        tick();
        @(negedge clk);
        checks++;
        if (!(req1_valid && req1_ready) || cyc != r + 1) begin
            errors++;
            $display("FAIL bp_next_accept: got ready1=%0b at +%0d, want ready1=1 at +1", req1_ready, cyc - r);
        end
        tick();
        req1_valid = 1'b0;
        wait_rsp(1'b1, r1);
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int t, r, rises0;
        send(1'b0, 4'd3, 4'd9, t);
        repeat (3) tick();
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        sb.delete();
        rises0 = rsp_rises;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, div_start, div_m, div_q,
             rsp0_quotient, rsp0_remain, rsp0_dz} !== '0) begin
            errors++;
            $display("FAIL midwait_reset: got v0=%0b start=%0b m=%0d q=%0d rq=%0d rr=%0d, want all 0",
                     rsp0_valid, div_start, div_m, div_q, rsp0_quotient, rsp0_remain);
        end
        repeat (15) tick();
        checks++;
        if (rsp_rises != rises0) begin
            errors++;
            $display("FAIL midwait_no_rsp: got %0d responses, want 0", rsp_rises - rises0);
        end
        send(1'b0, 4'd7, 4'd13, t);
        wait_rsp(1'b0, r);
        checks++;
        if (r - t != DIV_LAT + 2) begin
            errors++;
            $display("FAIL midwait_recover: got %0d cycles, want %0d", r - t, DIV_LAT + 2);
        end
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_div_zero();
        test_backpressure();
        test_reset_mid_wait();
        checks++;
        if (both_seen !== 1'b0) begin
            errors++;
            $display("FAIL rsp_exclusive: got both valid=1, want never");
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d outstanding, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
